// File: rtl/vedic3bit_accum_if.sv
// Stream interface between the 3-bit Vedic multiplier, the product accumulator
// and the consumer of group sums.
interface vedic3bit_accum_if #(
  parameter int ACC_W = 8
);
  // Both sides use strict valid/ready. A transfer happens on a rising edge where
  // valid and ready are both high. Once valid is raised, the producer holds its
  // payload (mul/in_last or result/terms/ovf) stable until the transfer. The
  // accumulator's ready depends only on its state and never on valid.
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       mul;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic [3:0]       terms;
  logic             ovf;

  modport master (
    output in_valid, mul, in_last, out_ready,
    input  in_ready, out_valid, result, terms, ovf
  );

  modport slave (
    input  in_valid, mul, in_last, out_ready,
    output in_ready, out_valid, result, terms, ovf
  );
endinterface

// File: rtl/vedic3bit_accum.sv
// Sums groups of up to N_TERMS 6-bit products into an ACC_W-bit dot-product
// result. The result is held on a valid/ready output until it is consumed.
module vedic3bit_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  vedic3bit_accum_if.slave     bus,
  output logic [0:0]           state_dbg
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [3:0]       cnt;
  logic             ovf_int;
  logic             accept;
  logic             close;
  logic [ACC_W:0]   sum;

  assign bus.in_ready = (state == ST_ACC);
  assign accept       = bus.in_valid & bus.in_ready;
  // The extra top bit of sum is the carry-out that feeds the sticky overflow.
  assign sum          = {1'b0, acc} + {{(ACC_W-5){1'b0}}, bus.mul};
  assign close        = (cnt == 4'(N_TERMS - 1)) | bus.in_last;
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_ACC;
      acc           <= '0;
      cnt           <= '0;
      ovf_int       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.terms     <= '0;
      bus.ovf       <= 1'b0;
    end else if (clr) begin
      // Abort wins over any same-cycle accept or output handshake; the last
      // delivered result/terms/ovf stay visible.
      state         <= ST_ACC;
      acc           <= '0;
      cnt           <= '0;
      ovf_int       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (close) begin
              bus.result    <= sum[ACC_W-1:0];
              bus.terms     <= cnt + 4'd1;
              bus.ovf       <= ovf_int | sum[ACC_W];
              bus.out_valid <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
              ovf_int       <= 1'b0;
              state         <= ST_DONE;
            end else begin
              acc     <= sum[ACC_W-1:0];
              ovf_int <= ovf_int | sum[ACC_W];
              cnt     <= cnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic3bit_accum.sv
// Drives identical product streams into an 8-bit and a 7-bit accumulator and
// checks both group sums against sums computed here.
module tb_vedic3bit_accum;

  localparam int N_TERMS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [0:0] st8;
  logic [0:0] st7;

  int tests = 0;
  int fails = 0;
  int grp_sum = 0;
  int grp_n = 0;

  logic [12:0] exp8_q[$];
  logic [11:0] exp7_q[$];

  vedic3bit_accum_if #(.ACC_W(8)) if8 ();
  vedic3bit_accum_if #(.ACC_W(7)) if7 ();

  vedic3bit_accum #(.N_TERMS(N_TERMS), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .bus(if8.slave), .state_dbg(st8)
  );
  vedic3bit_accum #(.N_TERMS(N_TERMS), .ACC_W(7)) dut7 (
    .clk(clk), .rst(rst), .clr(clr), .bus(if7.slave), .state_dbg(st7)
  );

  assign if7.in_valid  = if8.in_valid;
  assign if7.mul       = if8.mul;
  assign if7.in_last   = if8.in_last;
  assign if7.out_ready = if8.out_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output handshake pops one expected group per width.
  always @(negedge clk) begin
    if (!rst && if8.out_valid && if8.out_ready) begin
      if (exp8_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        check("w8_result_terms_ovf", {19'd0, if8.result, if8.terms, if8.ovf}, {19'd0, exp8_q.pop_front()});
        check("w7_out_valid", {31'd0, if7.out_valid}, 32'd1);
        check("w7_result_terms_ovf", {20'd0, if7.result, if7.terms, if7.ovf}, {20'd0, exp7_q.pop_front()});
        check("in_ready_in_done", {31'd0, if8.in_ready}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_group();
    exp8_q.push_back({8'(grp_sum), 4'(grp_n), (grp_sum > 255)});
    exp7_q.push_back({7'(grp_sum), 4'(grp_n), (grp_sum > 127)});
    grp_sum = 0;
    grp_n   = 0;
  endtask

  task automatic send(input logic [5:0] m, input logic last);
    int waited = 0;
    if8.in_valid = 1'b1;
    if8.mul      = m;
    if8.in_last  = last;
    @(negedge clk);
    while (!if8.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", {31'd0, (waited < 50)}, 32'd1);
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    if8.in_last  = 1'b0;
    grp_sum += int'(m);
    grp_n++;
    if (last || grp_n == N_TERMS) push_group();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0] r;
    if8.in_valid  = 1'b0;
    if8.mul       = '0;
    if8.in_last   = 1'b0;
    if8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, if8.in_ready}, 32'd1);
    check("rst_result",    {24'd0, if8.result}, 32'd0);
    check("rst_terms",     {28'd0, if8.terms}, 32'd0);
    check("rst_ovf",       {31'd0, if8.ovf}, 32'd0);
    check("rst_state",     {31'd0, st8}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Full group: 196 fits in 8 bits, wraps to 68 with ovf in 7 bits.
    repeat (4) send(6'd49, 1'b0);
    // Early close on the second term.
    send(6'd1, 1'b0);
    send(6'd2, 1'b1);
    idle(2);

    // Backpressure: held result while a product waits upstream.
    if8.out_ready = 1'b0;
    send(6'd10, 1'b0);
    send(6'd20, 1'b0);
    send(6'd30, 1'b0);
    send(6'd40, 1'b0);
    if8.in_valid = 1'b1;
    if8.mul      = 6'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, if8.out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, if8.in_ready}, 32'd0);
      check("bp_result",    {24'd0, if8.result}, 32'd100);
      @(posedge clk);
      #1;
    end
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_ready_after_release", {31'd0, if8.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    grp_sum = 9;
    grp_n   = 1;
    send(6'd1, 1'b1);
    idle(1);

    // Single-term group.
    send(6'd36, 1'b1);
    idle(1);

    // Random idle gaps between accepts.
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 3));
        r = 6'($urandom_range(0, 63));
        send(r, (i == 3));
      end
    end
    idle(2);

    // Abort mid-group, with a third product in the clr cycle.
    send(6'd10, 1'b0);
    send(6'd20, 1'b0);
    if8.in_valid = 1'b1;
    if8.mul      = 6'd30;
    clr          = 1'b1;
    @(posedge clk);
    #1;
    clr          = 1'b0;
    if8.in_valid = 1'b0;
    grp_sum = 0;
    grp_n   = 0;
    check("clr_state", {31'd0, st8}, 32'd0);
    repeat (4) send(6'd1, 1'b0);
    idle(2);

    // Abort while a result is pending.
    if8.out_ready = 1'b0;
    send(6'd50, 1'b1);
    void'(exp8_q.pop_back());
    void'(exp7_q.pop_back());
    @(negedge clk);
    check("done_out_valid", {31'd0, if8.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_done_out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("clr_done_in_ready",  {31'd0, if8.in_ready}, 32'd1);
    check("clr_done_result",    {24'd0, if8.result}, 32'd50);
    check("clr_done_terms",     {28'd0, if8.terms}, 32'd1);
    @(posedge clk);
    #1;
    if8.out_ready = 1'b1;

    // Asynchronous reset between edges, mid-group.
    send(6'd5, 1'b0);
    send(6'd6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("arst_in_ready",  {31'd0, if8.in_ready}, 32'd1);
    check("arst_result",    {24'd0, if8.result}, 32'd0);
    check("arst_terms",     {28'd0, if8.terms}, 32'd0);
    check("arst_w7_result", {25'd0, if7.result}, 32'd0);
    #1;
    rst = 1'b0;
    grp_sum = 0;
    grp_n   = 0;
    idle(1);
    send(6'd7, 1'b0);
    send(6'd8, 1'b1);
    idle(3);

    check("pending_w8", exp8_q.size(), 32'd0);
    check("pending_w7", exp7_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vedic3bit_accum.md
# vedic3bit_accum

Sequential accumulator that sits directly downstream of the 3-bit Vedic multiplier. It accepts the 6-bit products one per cycle over a valid/ready handshake, sums a group of up to N_TERMS products into a wider accumulator, and presents the group sum (dot-product result) on an output valid/ready handshake. Together with the multiplier, it forms a small multiply-accumulate datapath for dot products of 3-bit vectors.

## Interface
- N_TERMS, 4, maximum products per group; legal range 1..15
- ACC_W, 8, accumulator and result width; must be ≥ 6
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort: discard current group and any held result
- in_valid  input  1  product on mul is valid
- in_ready  output  1  block can accept a product this cycle
- mul  input  6  unsigned product from the multiplier
- in_last  input  1  qualifies the accepted product as the final term of the group (early close)
- out_valid  output  1  result, terms and ovf are valid and held
- out_ready  input  1  consumer accepts the result
- result  output  ACC_W  group sum modulo 2^ACC_W
- terms  output  4  number of products summed into result (1..N_TERMS)
- ovf  output  1  group sum exceeded 2^ACC_W − 1 at least once

## Operation
- Two states: ACC (collecting), DONE (holding result).
- Reset (async, rst high) → state ACC; acc=0, cnt=0, out_valid=0, result=0, terms=0, ovf=0.
- in_ready = 1 in ACC, 0 in DONE; it is combinational from state only and does not depend on in_valid.
- Accept = in_valid & in_ready. On accept in ACC:
  - acc ← acc + zero-extended mul, truncated to ACC_W.
  - Sticky ovf_int ← ovf_int | carry-out of that addition.
  - cnt ← cnt + 1.
- Group closes on the accept where cnt == N_TERMS−1 or in_last == 1, whichever comes first. On the closing accept:
  - result ← new acc; terms ← cnt+1; ovf ← new ovf_int; out_valid ← 1.
  - acc, cnt and ovf_int clear to 0; state → DONE.
- DONE: result, terms and ovf are held stable while out_valid=1 and out_ready=0. On out_ready=1: out_valid ← 0 and state → ACC. result, terms and ovf keep their last values after out_valid falls.
- in_valid while in DONE: ignored. The product is not consumed and the upstream stage must hold it.
- in_last without an accept has no effect.
- clr=1: next state is ACC; acc, cnt, ovf_int and out_valid go to 0. result, terms and ovf are unchanged. clr has priority over any simultaneous accept or output handshake, and a product presented in the same cycle is not counted.
- Arithmetic: all unsigned. With N_TERMS·63 < 2^ACC_W, ovf can never assert.

## Timing
- Per accept: one cycle; the accumulation is visible internally at the next edge.
- Latency: out_valid rises on the edge that registers the closing accept, i.e. the first cycle after the closing product was presented.
- Minimum group period: N_TERMS accept cycles + 1 DONE cycle (if out_ready is held high). There are no back-to-back groups without a DONE cycle.
- An output handshake and the first product of the next group cannot occur in the same cycle.
- Reset asserted mid-group or during DONE: all state clears immediately without waiting for clk. The pending result is lost.

## Test plan
- Default params: four accepts of mul=49 with out_ready=1 → out_valid high for one cycle after the 4th accept; result=196, terms=4, ovf=0; in_ready=0 during that cycle.
- ACC_W=7: four accepts of mul=49 → result=68 (196 mod 128), terms=4, ovf=1. The next group of mul=1,2 with in_last on the 2nd accept → result=3, terms=2, ovf=0.
- Backpressure: group closes with out_ready=0 for 5 cycles while in_valid=1 and mul=9 → result held and in_ready=0 throughout; the mul=9 product is first accepted in the cycle after out_ready goes high.
- Early close: single accept mul=36 with in_last=1 → result=36, terms=1. Random in_valid gaps (idle cycles between accepts) give the same sums as contiguous streams.
- clr after two accepts (mul=10,20) and in the same cycle as a third accept (mul=30) → no output. The next 4 accepts of mul=1 give result=4, terms=4. clr during DONE drops out_valid the next cycle.
- Async rst pulse between clock edges mid-group → outputs and in_ready reach their reset values before the next edge. The following group sums from zero.
